// File: rtl/boot_pkg.sv
// Shared constants and state encoding for the boot ROM loader.
// BOOT_CHECKSUM_EN (optional) enables the trailing checksum word; CSUM is only reachable then.
package boot_pkg;

  localparam logic [31:0] NOP_INST  = 32'h0000_0013;
  localparam int          HDR_BYTES = 4;

  typedef enum logic [2:0] {
    HDR,
    LOAD,
    CSUM,
    RUN,
    ERR
  } state_e;

endpackage

// File: rtl/boot_rom_loader_word_pack.sv
// Little-endian byte-to-word assembler: the 4th accepted byte completes a word
// and raises word_valid combinationally in that same cycle.
module word_pack
  import boot_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        word_valid,
  output logic [31:0] word
);

  logic [1:0]  cnt_q, cnt_d;
  logic [23:0] sr_q, sr_d;

  always_comb begin
    cnt_d = cnt_q;
    sr_d  = sr_q;
    if (clr) begin
      cnt_d = '0;
    end else if (in_valid) begin
      cnt_d = cnt_q + 2'd1;
      sr_d  = {in_data, sr_q[23:8]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      sr_q  <= '0;
    end else begin
      cnt_q <= cnt_d;
      sr_q  <= sr_d;
    end
  end

  // Only the three earlier bytes are stored; the last one arrives straight from the input.
  assign word_valid = in_valid && !clr && (cnt_q == 2'(HDR_BYTES - 1));
  assign word       = {in_data, sr_q};

endmodule

// File: rtl/boot_rom_loader.sv
// Instruction memory loaded from a valid/ready byte stream; holds the core in reset until loaded.
// Optional macro BOOT_CHECKSUM_EN adds a trailing 32-bit checksum word over the payload.
module boot_rom_loader
  import boot_pkg::*;
#(
  parameter int          DEPTH     = 1024,
  parameter int          AW        = 10,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ld_valid_i,
  input  logic [7:0]  ld_data_i,
  output logic        ld_ready_o,
  input  logic        reload_i,
  input  logic [31:0] inst_addr_i,
  output logic [31:0] inst_o,
  output logic        cpu_rst_o,
  output logic        load_done_o,
  output logic        load_err_o
);

`ifdef BOOT_CHECKSUM_EN
  localparam state_e PAYLOAD_DONE = CSUM;
`else
  localparam state_e PAYLOAD_DONE = RUN;
`endif

  state_e      state_q, state_d;
  logic [AW:0] word_cnt_q, word_cnt_d;
  logic [AW:0] n_q, n_d;
  logic        cpu_rst_q, cpu_rst_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
`ifdef BOOT_CHECKSUM_EN
  logic [31:0] sum_q, sum_d;
`endif

  logic [31:0] mem_q [DEPTH];
  logic        accept, pack_clr, word_valid, mem_we;
  logic [31:0] word;

  assign ld_ready_o = (state_q == HDR) || (state_q == LOAD) || (state_q == CSUM);
  assign accept     = ld_valid_i && ld_ready_o;

  word_pack u_pack (
    .clk        (clk),
    .rst        (rst),
    .clr        (pack_clr),
    .in_valid   (accept),
    .in_data    (ld_data_i),
    .word_valid (word_valid),
    .word       (word)
  );

  always_comb begin
    state_d    = state_q;
    word_cnt_d = word_cnt_q;
    n_d        = n_q;
    pack_clr   = 1'b0;
    mem_we     = 1'b0;
`ifdef BOOT_CHECKSUM_EN
    sum_d      = sum_q;
`endif
    case (state_q)
      HDR: begin
        if (word_valid) begin
          word_cnt_d = '0;
          n_d        = word[AW:0];
`ifdef BOOT_CHECKSUM_EN
          sum_d      = '0;
`endif
          if (word > 32'(DEPTH))  state_d = ERR;
          else if (word == '0)    state_d = PAYLOAD_DONE;
          else                    state_d = LOAD;
        end
      end
      LOAD: begin
        if (word_valid) begin
          mem_we     = 1'b1;
          word_cnt_d = word_cnt_q + 1'b1;
`ifdef BOOT_CHECKSUM_EN
          sum_d      = sum_q + word;
`endif
          if (word_cnt_q + 1'b1 == n_q) state_d = PAYLOAD_DONE;
        end
      end
`ifdef BOOT_CHECKSUM_EN
      CSUM: begin
        if (word_valid) state_d = (word == sum_q) ? RUN : ERR;
      end
`endif
      RUN, ERR: begin
        if (reload_i) begin
          state_d    = HDR;
          word_cnt_d = '0;
          pack_clr   = 1'b1;
        end
      end
      default: state_d = HDR;
    endcase
    cpu_rst_d = (state_d != RUN);
    done_d    = (state_d == RUN);
    err_d     = (state_d == ERR);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= HDR;
      word_cnt_q <= '0;
      n_q        <= '0;
      cpu_rst_q  <= 1'b1;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
`ifdef BOOT_CHECKSUM_EN
      sum_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      word_cnt_q <= word_cnt_d;
      n_q        <= n_d;
      cpu_rst_q  <= cpu_rst_d;
      done_q     <= done_d;
      err_q      <= err_d;
`ifdef BOOT_CHECKSUM_EN
      sum_q      <= sum_d;
`endif
    end
  end

  // Contents survive reset on purpose; only the fetch gate below hides them.
  always_ff @(posedge clk) begin
    if (!rst && mem_we) mem_q[word_cnt_q[AW-1:0]] <= word;
  end

  assign cpu_rst_o   = cpu_rst_q;
  assign load_done_o = done_q;
  assign load_err_o  = err_q;

  logic [31:0] off;
  logic        unused_off_lsb;
  assign off            = inst_addr_i - BASE_ADDR;
  assign unused_off_lsb = ^off[1:0];

  // Words beyond the loaded image read as NOP rather than stale contents.
  always_comb begin
    inst_o = NOP_INST;
    if (state_q == RUN && off[31:2] < 30'(word_cnt_q)) inst_o = mem_q[off[AW+1:2]];
  end

endmodule
